// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet controller.
// The optional ACK/NAK responder is enabled by defining UART_PKT_ACK_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CHK,
    COMMIT
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK         = 8'h15;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x DATA_BITS storage with independent write and read
// pointers, both rewound by clr. The read port feeds the commit burst.
module uart_pkt_buf #(
  parameter int DATA_BITS = 8,
  parameter int MAX_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clr,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [DATA_BITS-1:0] mem [MAX_LEN];
  logic [PW-1:0]        wr_idx;
  logic [PW-1:0]        rd_idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr) wr_idx <= wr_idx + 1'b1;
      if (rd) rd_idx <= rd_idx + 1'b1;
    end
  end

  // NOTE: the array is deliberately not reset; every entry read during a commit was written by the same packet.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Framed write-packet parser and register-burst committer behind the UART RX.
// Define UART_PKT_ACK_EN to add the tx_valid/tx_data/tx_ready ACK/NAK responder.
module uart_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS   = 8,
  parameter int                   ADDR_W      = 4,
  parameter int                   MAX_LEN     = 8,
  parameter int                   TIMEOUT_CYC = 100000,
  parameter logic [DATA_BITS-1:0] SOF         = DATA_BITS'(SOF_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic [5:0]           led
`ifdef UART_PKT_ACK_EN
  ,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [DATA_BITS-1:0] tx_data
`endif
);

  localparam int                   CW        = $clog2(MAX_LEN + 1);
  localparam int                   TW        = $clog2(TIMEOUT_CYC);
  localparam logic [DATA_BITS-1:0] MAX_LEN_B = DATA_BITS'(MAX_LEN);

  state_t                state_q, state_d;
  logic                  rx_valid_q;
  logic                  byte_stb;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  chk_q, chk_d;
  logic [TW-1:0]         tmo_q;
  logic                  tmo_hit;
  logic [5:0]            last_q;
  logic                  set_chk, set_len, set_tmo;
  logic                  buf_wr;
  logic [DATA_BITS-1:0]  buf_rd_data;
  logic                  tx_busy;

  assign byte_stb = rx_valid & ~rx_valid_q;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign busy     = (state_q != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    set_chk  = 1'b0;
    set_len  = 1'b0;
    set_tmo  = 1'b0;
    buf_wr   = 1'b0;
    wr_en    = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (byte_stb && rx_data == SOF && !tx_busy) state_d = ADDR;
      end
      ADDR: if (byte_stb) begin
        base_d  = rx_data[ADDR_W-1:0];
        chk_d   = rx_data;
        state_d = LEN;
      end
      LEN: if (byte_stb) begin
        if (rx_data == '0 || rx_data > MAX_LEN_B) begin
          set_len = 1'b1;
          state_d = IDLE;
        end else begin
          len_d   = CW'(rx_data);
          chk_d   = chk_q ^ rx_data;
          state_d = DATA;
        end
      end
      DATA: if (byte_stb) begin
        buf_wr = 1'b1;
        chk_d  = chk_q ^ rx_data;
        idx_d  = idx_q + 1'b1;
        if (idx_q + 1'b1 == len_q) state_d = CHK;
      end
      CHK: if (byte_stb) begin
        idx_d = '0;
        if (rx_data == chk_q) begin
          state_d = COMMIT;
        end else begin
          set_chk = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        if (idx_q == len_q) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end else begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A byte landing on the terminal count wins over the timeout.
    if ((state_q inside {ADDR, LEN, DATA, CHK}) && !byte_stb && tmo_hit) begin
      set_tmo = 1'b1;
      state_d = IDLE;
    end
  end

  assign wr_addr = wr_en ? base_q + ADDR_W'(idx_q) : '0;
  assign wr_data = wr_en ? buf_rd_data : '0;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rx_valid_q  <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      last_q      <= '0;
      led         <= 6'h3F;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      err_chk     <= set_chk;
      err_len     <= set_len;
      err_timeout <= set_tmo;
      if (byte_stb || state_q == IDLE || state_q == COMMIT) tmo_q <= '0;
      else                                                  tmo_q <= tmo_q + 1'b1;
      if (wr_en)    last_q <= buf_rd_data[5:0];
      if (pkt_done) led    <= ~last_q;
    end
  end

  uart_pkt_buf #(
    .DATA_BITS (DATA_BITS),
    .MAX_LEN   (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (state_q == IDLE),
    .wr      (buf_wr),
    .wr_data (rx_data),
    .rd      (wr_en),
    .rd_data (buf_rd_data)
  );

`ifdef UART_PKT_ACK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end else if (pkt_done) begin
      tx_valid <= 1'b1;
      tx_data  <= DATA_BITS'(ACK);
    end else if (set_chk || set_len) begin
      tx_valid <= 1'b1;
      tx_data  <= DATA_BITS'(NAK);
    end
  end
  assign tx_busy = tx_valid;
`else
  assign tx_busy = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Scoreboard bench for uart_pkt_ctrl: stimulus queues expected events, a monitor
// pops and compares them whenever the DUT strobes a write, done or error.
module tb_uart_pkt_ctrl;

  localparam int TMO = 64;

  typedef enum int {EV_WR, EV_DONE, EV_ECHK, EV_ELEN, EV_ETMO} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [5:0] led;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en, busy, pkt_done, err_chk, err_len, err_timeout;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] led;
`ifdef UART_PKT_ACK_EN
  logic       tx_valid;
  logic [7:0] tx_data;
`endif

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  logic       led_pend = 1'b0;
  logic [5:0] led_exp = 6'h3F;

  always #5 clk = ~clk;

  uart_pkt_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .led         (led)
`ifdef UART_PKT_ACK_EN
    ,
    .tx_ready    (1'b1),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(ev_kind_t k, logic [3:0] a, logic [7:0] d, logic [5:0] l);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.led = l;
    return e;
  endfunction

  task automatic drive_rise(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold = 4);
    drive_rise(b);
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !led_pend) break;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    ev_t      e;
    ev_kind_t k;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        led_pend = 1'b0;
      end else begin
        if (led_pend) begin
          check("led", led, led_exp);
          led_pend = 1'b0;
        end
        if (wr_en | pkt_done | err_chk | err_len | err_timeout) begin
          check("one_event", $countones({wr_en, pkt_done, err_chk, err_len, err_timeout}), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_event", {27'd0, wr_en, pkt_done, err_chk, err_len, err_timeout}, 0);
          end else begin
            e = exp_q.pop_front();
            k = wr_en ? EV_WR : pkt_done ? EV_DONE : err_chk ? EV_ECHK : err_len ? EV_ELEN : EV_ETMO;
            check("event_kind", k, e.kind);
            if (e.kind == EV_WR) begin
              check("wr_addr", wr_addr, e.addr);
              check("wr_data", wr_data, e.data);
            end
            if (e.kind == EV_DONE) begin
              led_pend = 1'b1;
              led_exp  = e.led;
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {pkt_done, err_chk, err_len, err_timeout}, 0);
    check("rst_led", led, 6'h3F);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Valid packet with explicit commit timing.
    exp_q.push_back(mk(EV_WR, 4'h3, 8'h11, 0));
    exp_q.push_back(mk(EV_WR, 4'h4, 8'h22, 0));
    exp_q.push_back(mk(EV_DONE, 0, 0, 6'h1D));
    send_pkt('{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22});
    check("busy_mid_pkt", busy, 1);
    drive_rise(8'h32);
    @(posedge clk); #1;
    check("commit_first_cycle", {wr_en, wr_addr}, {1'b1, 4'h3});
    @(posedge clk); #1;
    check("commit_second_cycle", {wr_en, wr_addr}, {1'b1, 4'h4});
    @(posedge clk); #1;
    check("done_after_burst", {wr_en, pkt_done}, 2'b01);
    rx_valid = 1'b0;
    wait_idle("valid");
    check("led_valid", led, 6'h1D);

    // Address wrap.
    exp_q.push_back(mk(EV_WR, 4'hF, 8'hAA, 0));
    exp_q.push_back(mk(EV_WR, 4'h0, 8'h55, 0));
    exp_q.push_back(mk(EV_DONE, 0, 0, 6'h2A));
    send_pkt('{8'hA5, 8'h0F, 8'h02, 8'hAA, 8'h55, 8'hF2});
    wait_idle("wrap");

    // Bad checksum, then a good packet is accepted.
    exp_q.push_back(mk(EV_ECHK, 0, 0, 0));
    send_pkt('{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33});
    wait_idle("badchk");
    check("led_after_badchk", led, 6'h2A);
    exp_q.push_back(mk(EV_WR, 4'h5, 8'h3C, 0));
    exp_q.push_back(mk(EV_DONE, 0, 0, 6'h03));
    send_pkt('{8'hA5, 8'h05, 8'h01, 8'h3C, 8'h38});
    wait_idle("after_badchk");

    // Illegal lengths 0 and MAX_LEN+1.
    exp_q.push_back(mk(EV_ELEN, 0, 0, 0));
    send_pkt('{8'hA5, 8'h03, 8'h00});
    wait_idle("len0");
    exp_q.push_back(mk(EV_ELEN, 0, 0, 0));
    send_pkt('{8'hA5, 8'h03, 8'h09});
    wait_idle("len9");
    check("led_after_len", led, 6'h03);

    // Held rx_valid level counts as a single byte.
    exp_q.push_back(mk(EV_WR, 4'h3, 8'h10, 0));
    exp_q.push_back(mk(EV_DONE, 0, 0, 6'h2F));
    send_byte(8'hA5, 16);
    send_pkt('{8'h03, 8'h01, 8'h10, 8'h12});
    wait_idle("held_valid");

    // Inter-byte timeout after A5 03.
    exp_q.push_back(mk(EV_ETMO, 0, 0, 0));
    send_pkt('{8'hA5, 8'h03});
    check("busy_before_tmo", busy, 1);
    wait_idle("timeout");

    // Reset during the second write of a 4-byte burst.
    exp_q.push_back(mk(EV_WR, 4'h2, 8'h01, 0));
    send_pkt('{8'hA5, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04});
    drive_rise(8'h02);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("second_write_active", {wr_en, wr_addr}, {1'b1, 4'h3});
    n_rst    = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_wr_addr", wr_addr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_led", led, 6'h3F);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (20) @(posedge clk);
    wait_idle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
Command controller behind the UART receiver.
- Consumes received bytes, parses framed write packets and checks them.
- Commits each validated payload as a burst of register writes to a downstream register file.
- Sits between the UART RX datapath and the board register bank and LEDs.
- Bad or stalled packets are dropped without side effects.

Parameters:
DATA_BITS, 8, UART byte width; rx_data width and all packet fields.
ADDR_W, 4, register address width; write addresses wrap modulo 2^ADDR_W.
MAX_LEN, 8, maximum payload bytes per packet (1..MAX_LEN legal).
TIMEOUT_CYC, 100000, clk cycles allowed between consecutive bytes inside a packet.
SOF, 8'hA5, start-of-frame byte.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous reset, active-low
rx_valid  in  1  UART RX valid; a level held for several cycles per byte
rx_data  in  DATA_BITS  UART RX byte, stable while rx_valid is high
wr_en  out  1  register write strobe, one cycle per byte
wr_addr  out  ADDR_W  register write address
wr_data  out  DATA_BITS  register write data
busy  out  1  high in any state other than IDLE
pkt_done  out  1  one-cycle pulse after the last commit write
err_chk  out  1  one-cycle pulse on checksum mismatch
err_len  out  1  one-cycle pulse on illegal LEN
err_timeout  out  1  one-cycle pulse on inter-byte timeout
led  out  6  ~last committed wr_data[5:0]; LEDs are active-low

Behaviour:
- Reset: state IDLE. All outputs 0 except led = 6'h3F. Counters, buffer pointers and the registered copy of rx_valid clear.
- Byte strobe: byte_stb = rx_valid & ~rx_valid_q, where rx_valid_q is registered. A byte is accepted in the byte_stb cycle; the held level never counts twice.
- Packet format: SOF, ADDR, LEN, LEN payload bytes, CHK.
  - CHK = ADDR ^ LEN ^ payload[0] ^ ... ^ payload[LEN-1].
  - ADDR uses its low ADDR_W bits.
- State IDLE: byte == SOF -> ADDR. Any other byte is ignored.
- State ADDR: latch base address and seed the checksum -> LEN.
- State LEN: if LEN == 0 or LEN > MAX_LEN, pulse err_len and go to IDLE. Otherwise latch LEN -> DATA.
- State DATA: store each byte in the payload buffer at index i and fold it into the checksum. After byte LEN-1 -> CHK.
- State CHK: on match -> COMMIT. On mismatch, pulse err_chk and go to IDLE; the buffer is discarded and no write occurs.
- State COMMIT:
  - wr_en is high for exactly LEN consecutive cycles, starting the cycle after the CHK byte_stb.
  - Write i drives wr_addr = base + i (mod 2^ADDR_W) and wr_data = buffer[i].
  - Cycle after the last write: pulse pkt_done, update led, go to IDLE.
  - Bytes arriving during COMMIT are ignored; the UART byte time far exceeds MAX_LEN cycles.
- Timeout:
  - The counter clears on every byte_stb and in IDLE, and counts in ADDR/LEN/DATA/CHK.
  - At TIMEOUT_CYC-1: pulse err_timeout and go to IDLE.
  - If byte_stb coincides with the terminal count, the byte wins and the counter clears.
- Error pulses are mutually exclusive. At most one of pkt_done / err_* is high per cycle.
- Reset mid-packet or mid-commit: immediate IDLE with no further writes; a partial burst is not resumed.

Optional Feature:
UART_PKT_ACK_EN
- Defined: adds outputs tx_valid (1) and tx_data (DATA_BITS) and input tx_ready (1). After pkt_done the block sends 8'h06; after err_chk or err_len it sends 8'h15. tx_valid holds until the cycle tx_ready is high. While an ACK/NAK is pending, IDLE ignores SOF.
- Undefined: the ports are absent and no response is generated.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, ADDR, LEN, DATA, CHK, COMMIT), SOF default, ACK 8'h06, NAK 8'h15.
- Sub-module uart_pkt_buf: MAX_LEN x DATA_BITS register array with write index, read index and clear. It provides the commit read path.

Test Plan:
- Valid packet: A5 03 02 11 22 32 -> wr_en for 2 cycles writing (3,0x11) then (4,0x22); pkt_done 1 cycle later; led = 6'h1D.
- Address wrap: A5 0F 02 AA 55 F2 -> writes (F,0xAA) then (0,0x55); pkt_done.
- Bad checksum: A5 03 02 11 22 33 -> err_chk pulse, no wr_en; a following valid packet is accepted.
- Illegal length: A5 03 00 and A5 03 09 -> err_len each time, IDLE, no writes.
- Timeout and held valid: stop after A5 03 for TIMEOUT_CYC cycles -> err_timeout, busy falls. Holding rx_valid high for 16 cycles counts as one byte.
- Reset mid-commit: assert n_rst during the second write of a 4-byte packet -> wr_en=0 immediately; outputs at reset values.
